// File: rtl/tx_pkt_arbiter.sv
// Packet-granular two-source arbiter in front of the MAC transmit byte interface.
// Locks the grant for a whole sop..eop packet, alternates round-robin between
// sources, discards stray bytes seen outside a packet and truncates packets
// longer than MAX_LEN bytes (forced eop+err, remainder flushed).
// Optional build macro TX_ARB_STRICT_PRIO_EN: source 0 always wins a tie.
module tx_pkt_arbiter #(
  parameter int unsigned MAX_LEN = 1514,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             tx_clk,
  input  logic             rst,
  input  logic [7:0]       s0_data,
  input  logic             s0_sop,
  input  logic             s0_eop,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [7:0]       s1_data,
  input  logic             s1_sop,
  input  logic             s1_eop,
  input  logic             s1_valid,
  output logic             s1_ready,
  output logic [7:0]       m_data,
  output logic             m_sop,
  output logic             m_eop,
  output logic             m_err,
  output logic             m_wren,
  input  logic             m_rdy,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] trunc_count
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {StIdle, StXfer, StFlush} state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;  // 1: source 1 owned the previous packet
  logic [LenW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] trunc_q, trunc_d;

  logic       sel_valid, sel_sop, sel_eop;
  logic [7:0] sel_data;
  logic       drop0, drop1, cand0, cand1, pick1;
  logic [CNT_W:0] drop_sum;

  // Fields of the currently granted source.
  always_comb begin
    if (grant_q[1]) begin
      sel_valid = s1_valid;
      sel_sop   = s1_sop;
      sel_eop   = s1_eop;
      sel_data  = s1_data;
    end else begin
      sel_valid = s0_valid;
      sel_sop   = s0_sop;
      sel_eop   = s0_eop;
      sel_data  = s0_data;
    end
  end

  // Next-state, handshakes and the zero-latency MAC datapath.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    drop_d     = drop_q;
    trunc_d    = trunc_q;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    m_data     = 8'h00;
    m_sop      = 1'b0;
    m_eop      = 1'b0;
    m_err      = 1'b0;
    m_wren     = 1'b0;
    drop0      = 1'b0;
    drop1      = 1'b0;
    pick1      = 1'b0;
    drop_sum   = {1'b0, drop_q};
    cand0      = s0_valid & s0_sop;
    cand1      = s1_valid & s1_sop;

    unique case (state_q)
      StIdle: begin
        // Non-sop bytes outside a packet are swallowed and counted.
        drop0    = s0_valid & ~s0_sop;
        drop1    = s1_valid & ~s1_sop;
        s0_ready = drop0;
        s1_ready = drop1;
        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop0) + (CNT_W+1)'(drop1);
        drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
`ifdef TX_ARB_STRICT_PRIO_EN
        pick1 = cand1 & ~cand0;
`else
        pick1 = cand1 & (~cand0 | ~last_q);
`endif
        // Arbitration cycle only; the sop byte moves in StXfer.
        if (cand0 | cand1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          state_d = StXfer;
        end
      end
      StXfer: begin
        s0_ready = grant_q[0] & m_rdy;
        s1_ready = grant_q[1] & m_rdy;
        m_wren   = sel_valid & m_rdy;
        if (m_wren) begin
          m_data     = sel_data;
          m_sop      = sel_sop;
          m_eop      = sel_eop;
          byte_cnt_d = byte_cnt_q + LenW'(1);
          if (sel_eop) begin
            state_d    = StIdle;
            last_d     = grant_q[1];
            grant_d    = 2'b00;
            byte_cnt_d = '0;
          end else if (byte_cnt_q == LenW'(MAX_LEN - 1)) begin
            // Byte MAX_LEN of an unterminated packet: close it as errored.
            m_eop   = 1'b1;
            m_err   = 1'b1;
            trunc_d = (&trunc_q) ? trunc_q : trunc_q + CNT_W'(1);
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        // Drain the rest of the oversize packet without touching the MAC.
        s0_ready = grant_q[0];
        s1_ready = grant_q[1];
        if (sel_valid & sel_eop) begin
          state_d    = StIdle;
          last_d     = grant_q[1];
          grant_d    = 2'b00;
          byte_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Nothing is consumed or written while reset is held.
    if (rst) begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      m_wren   = 1'b0;
      m_data   = 8'h00;
      m_sop    = 1'b0;
      m_eop    = 1'b0;
      m_err    = 1'b0;
    end
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= 2'b00;
      last_q     <= 1'b1;
      byte_cnt_q <= '0;
      drop_q     <= '0;
      trunc_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      drop_q     <= drop_d;
      trunc_q    <= trunc_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != StIdle);
  assign drop_count  = drop_q;
  assign trunc_count = trunc_q;

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Self-checking bench for tx_pkt_arbiter: a cycle table for handshake detail,
// then queue-driven packet sequences for the multi-cycle scenarios.
module tb_tx_pkt_arbiter;

  localparam int unsigned MAX_LEN = 1514;
  localparam int unsigned CNT_W   = 16;
`ifdef TX_ARB_STRICT_PRIO_EN
  localparam bit Strict = 1'b1;
`else
  localparam bit Strict = 1'b0;
`endif

  logic             tx_clk, rst;
  logic [7:0]       s0_data, s1_data, m_data;
  logic             s0_sop, s0_eop, s0_valid, s0_ready;
  logic             s1_sop, s1_eop, s1_valid, s1_ready;
  logic             m_sop, m_eop, m_err, m_wren, m_rdy, busy;
  logic [1:0]       grant;
  logic [CNT_W-1:0] drop_count, trunc_count;

  tx_pkt_arbiter #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .tx_clk(tx_clk), .rst(rst),
    .s0_data(s0_data), .s0_sop(s0_sop), .s0_eop(s0_eop), .s0_valid(s0_valid),
    .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_sop(s1_sop), .s1_eop(s1_eop), .s1_valid(s1_valid),
    .s1_ready(s1_ready),
    .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop), .m_err(m_err), .m_wren(m_wren),
    .m_rdy(m_rdy), .grant(grant), .busy(busy),
    .drop_count(drop_count), .trunc_count(trunc_count)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic       rst;
    logic       v0, sop0, eop0;
    logic [7:0] d0;
    logic       v1, sop1, eop1;
    logic [7:0] d1;
    logic       rdy;
    logic       er0, er1, ew, es, ee, eerr;
    logic [7:0] ed;
    logic [1:0] eg;
    logic       eb;
    logic [7:0] edr;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic v0, input logic s0, input logic e0, input logic [7:0] d0,
    input logic v1, input logic s1, input logic e1, input logic [7:0] d1, input logic rdy,
    input logic er0, input logic er1, input logic ew, input logic es, input logic ee,
    input logic eerr, input logic [7:0] ed, input logic [1:0] eg, input logic eb,
    input logic [7:0] edr);
    vec_t v;
    v.rst = r; v.v0 = v0; v.sop0 = s0; v.eop0 = e0; v.d0 = d0;
    v.v1 = v1; v.sop1 = s1; v.eop1 = e1; v.d1 = d1; v.rdy = rdy;
    v.er0 = er0; v.er1 = er1; v.ew = ew; v.es = es; v.ee = ee; v.eerr = eerr;
    v.ed = ed; v.eg = eg; v.eb = eb; v.edr = edr;
    return v;
  endfunction

  vec_t tbl[14];

  // ---------------- queue-driven sources / MAC monitor ----------------
  typedef struct {
    logic [7:0] d;
    logic       sop, eop;
  } byte_t;
  typedef struct {
    logic [7:0] d;
    logic       sop, eop, err;
    logic [1:0] g;
  } out_t;

  byte_t q0[$], q1[$];
  out_t  outq[$];
  int    cyc = 0;
  int    first_w, last_w, viol;
  logic  last_s0r, last_s1r, last_wren, last_busy;
  logic  [1:0] last_grant;

  task automatic add_pkt(input int src, input int len, input logic [7:0] base);
    byte_t b;
    for (int i = 0; i < len; i++) begin
      b.d   = base + 8'(i);
      b.sop = (i == 0);
      b.eop = (i == len - 1);
      if (src == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  // Drive heads of queues, sample mid-cycle, retire handshakes, advance a cycle.
  task automatic step();
    out_t o;
    if (q0.size() != 0) begin
      s0_valid = 1'b1; s0_data = q0[0].d; s0_sop = q0[0].sop; s0_eop = q0[0].eop;
    end else begin
      s0_valid = 1'b0; s0_data = 8'h00; s0_sop = 1'b0; s0_eop = 1'b0;
    end
    if (q1.size() != 0) begin
      s1_valid = 1'b1; s1_data = q1[0].d; s1_sop = q1[0].sop; s1_eop = q1[0].eop;
    end else begin
      s1_valid = 1'b0; s1_data = 8'h00; s1_sop = 1'b0; s1_eop = 1'b0;
    end
    #1;
    last_s0r = s0_ready; last_s1r = s1_ready; last_wren = m_wren;
    last_busy = busy; last_grant = grant;
    if (m_wren) begin
      o.d = m_data; o.sop = m_sop; o.eop = m_eop; o.err = m_err; o.g = grant;
      outq.push_back(o);
      if (first_w < 0) first_w = cyc;
      last_w = cyc;
    end
    if (!m_rdy && (m_wren || s0_ready)) viol++;
    if (s0_valid && s0_ready) void'(q0.pop_front());
    if (s1_valid && s1_ready) void'(q1.pop_front());
    cyc++;
    @(negedge tx_clk);
  endtask

  task automatic run_drain(input int max_cyc, input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk({name, "_drain_in_budget"}, 32'(n < max_cyc), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, bad, k, i0, i1, n, e;
    logic [5:0] ord;

    rst = 1'b1; m_rdy = 1'b1;
    s0_valid = 0; s0_sop = 0; s0_eop = 0; s0_data = 0;
    s1_valid = 0; s1_sop = 0; s1_eop = 0; s1_data = 0;

    //          r  v0 s0 e0 d0     v1 s1 e1 d1     rdy er0 er1 w sop eop err data  g      b  drop
    tbl[0]  = mk(1, 1, 1, 0, 8'h10, 1, 0, 0, 8'hA0, 1,  0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 8'd0);
    tbl[1]  = mk(1, 1, 1, 0, 8'h10, 1, 0, 0, 8'hA0, 1,  0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 8'd0);
    tbl[2]  = mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 8'hA1, 1,  0,  1, 0, 0, 0, 0, 8'h00, 2'b00, 0, 8'd0);
    tbl[3]  = mk(0, 1, 0, 0, 8'hB0, 1, 0, 0, 8'hA2, 1,  1,  1, 0, 0, 0, 0, 8'h00, 2'b00, 0, 8'd1);
    tbl[4]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1,  0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 8'd3);
    tbl[5]  = mk(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h55, 1,  0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 8'd3);
    tbl[6]  = mk(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h55, 1,  0,  1, 1, 1, 0, 0, 8'h55, 2'b10, 1, 8'd3);
    tbl[7]  = mk(0, 1, 1, 0, 8'h10, 1, 0, 1, 8'h66, 1,  0,  1, 1, 0, 1, 0, 8'h66, 2'b10, 1, 8'd3);
    tbl[8]  = mk(0, 1, 1, 0, 8'h10, 0, 0, 0, 8'h00, 1,  0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 8'd3);
    tbl[9]  = mk(0, 1, 1, 0, 8'h10, 0, 0, 0, 8'h00, 0,  0,  0, 0, 0, 0, 0, 8'h00, 2'b01, 1, 8'd3);
    tbl[10] = mk(0, 1, 1, 1, 8'h10, 0, 0, 0, 8'h00, 1,  1,  0, 1, 1, 1, 0, 8'h10, 2'b01, 1, 8'd3);
    tbl[11] = mk(0, 1, 1, 1, 8'h11, 1, 1, 1, 8'h22, 1,  0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 8'd3);
    tbl[12] = Strict ?
              mk(0, 1, 1, 1, 8'h11, 1, 1, 1, 8'h22, 1,  1,  0, 1, 1, 1, 0, 8'h11, 2'b01, 1, 8'd3) :
              mk(0, 1, 1, 1, 8'h11, 1, 1, 1, 8'h22, 1,  0,  1, 1, 1, 1, 0, 8'h22, 2'b10, 1, 8'd3);
    tbl[13] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1,  0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 8'd3);

    @(negedge tx_clk);
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; m_rdy = tbl[i].rdy;
      s0_valid = tbl[i].v0; s0_sop = tbl[i].sop0; s0_eop = tbl[i].eop0; s0_data = tbl[i].d0;
      s1_valid = tbl[i].v1; s1_sop = tbl[i].sop1; s1_eop = tbl[i].eop1; s1_data = tbl[i].d1;
      #1;
      chk($sformatf("vec%0d", i),
          32'({s0_ready, s1_ready, m_wren, m_sop, m_eop, m_err, m_data, grant, busy,
               drop_count[7:0]}),
          32'({tbl[i].er0, tbl[i].er1, tbl[i].ew, tbl[i].es, tbl[i].ee, tbl[i].eerr,
               tbl[i].ed, tbl[i].eg, tbl[i].eb, tbl[i].edr}));
      @(negedge tx_clk);
    end

    // A: single 64-byte s0 packet, no backpressure.
    outq.delete(); first_w = -1; last_w = -1; viol = 0;
    add_pkt(0, 64, 8'h40);
    t0 = cyc;
    run_drain(200, "A");
    step();
    chk("A_busy_after_eop", 32'(last_busy), 32'd0);
    chk("A_len", 32'(outq.size()), 32'd64);
    chk("A_first_write_cycle", 32'(first_w - t0), 32'd1);
    chk("A_contiguous", 32'(last_w - first_w), 32'd63);
    bad = 0;
    foreach (outq[i]) begin
      if (outq[i].d !== 8'h40 + 8'(i) || outq[i].sop !== (i == 0) ||
          outq[i].eop !== (i == 63) || outq[i].err !== 1'b0 || outq[i].g !== 2'b01) bad++;
    end
    chk("A_bytes", 32'(bad), 32'd0);

    // B: both sources, three back-to-back 10-byte packets each, from reset.
    rst = 1'b1; step(); rst = 1'b0;
    outq.delete();
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, 10, 8'h10 * 8'(p + 1));
      add_pkt(1, 10, 8'h90 + 8'h10 * 8'(p));
    end
    run_drain(400, "B");
    step();
    chk("B_len", 32'(outq.size()), 32'd60);
    k = 0; ord = '0; i0 = 0; i1 = 0; bad = 0;
    foreach (outq[i]) begin
      if (outq[i].sop && k < 6) begin
        ord[k] = outq[i].g[1];
        k++;
      end
      if (outq[i].g == 2'b01) begin
        e = 16 * (i0 / 10 + 1) + i0 % 10;
        if (outq[i].d !== 8'(e) || outq[i].sop !== (i0 % 10 == 0) ||
            outq[i].eop !== (i0 % 10 == 9)) bad++;
        i0++;
      end else begin
        e = 8'h90 + 16 * (i1 / 10) + i1 % 10;
        if (outq[i].d !== 8'(e) || outq[i].sop !== (i1 % 10 == 0) ||
            outq[i].eop !== (i1 % 10 == 9)) bad++;
        i1++;
      end
    end
    chk("B_order", 32'(ord), Strict ? 32'b111000 : 32'b101010);
    chk("B_bytes", 32'(bad), 32'd0);

    // C: five stray s1 bytes in idle, then a clean s1 packet.
    outq.delete();
    for (int i = 0; i < 5; i++) begin
      byte_t b;
      b.d = 8'hE0 + 8'(i); b.sop = 1'b0; b.eop = 1'b0;
      q1.push_back(b);
    end
    add_pkt(1, 8, 8'h70);
    run_drain(100, "C");
    step();
    chk("C_drop_count", 32'(drop_count), 32'd5);
    chk("C_len", 32'(outq.size()), 32'd8);
    bad = 0;
    foreach (outq[i]) begin
      if (outq[i].d !== 8'h70 + 8'(i) || outq[i].sop !== (i == 0) ||
          outq[i].eop !== (i == 7) || outq[i].g !== 2'b10) bad++;
    end
    chk("C_bytes", 32'(bad), 32'd0);

    // D: oversize s0 packet truncated, s1 waiting behind it.
    outq.delete();
    add_pkt(0, 1600, 8'h00);
    add_pkt(1, 10, 8'hC0);
    run_drain(2000, "D");
    step();
    chk("D_len", 32'(outq.size()), 32'd1524);
    chk("D_trunc_count", 32'(trunc_count), 32'd1);
    bad = 0;
    foreach (outq[i]) begin
      if (i < 1514) begin
        if (outq[i].d !== 8'(i) || outq[i].sop !== (i == 0) || outq[i].eop !== (i == 1513) ||
            outq[i].err !== (i == 1513) || outq[i].g !== 2'b01) bad++;
      end else begin
        if (outq[i].d !== 8'hC0 + 8'(i - 1514) || outq[i].sop !== (i == 1514) ||
            outq[i].eop !== (i == 1523) || outq[i].err !== 1'b0 || outq[i].g !== 2'b10) bad++;
      end
    end
    chk("D_bytes", 32'(bad), 32'd0);

    // E: seven-cycle m_rdy stall in the middle of a packet.
    outq.delete();
    add_pkt(0, 30, 8'h20);
    repeat (12) step();
    m_rdy = 1'b0; viol = 0;
    repeat (7) step();
    chk("E_no_handshake_while_stalled", 32'(viol), 32'd0);
    chk("E_bytes_before_resume", 32'(outq.size()), 32'd11);
    m_rdy = 1'b1;
    run_drain(100, "E");
    step();
    chk("E_len", 32'(outq.size()), 32'd30);
    bad = 0;
    foreach (outq[i]) begin
      if (outq[i].d !== 8'h20 + 8'(i) || outq[i].sop !== (i == 0) || outq[i].eop !== (i == 29))
        bad++;
    end
    chk("E_bytes", 32'(bad), 32'd0);

    // F: reset in the middle of a transfer.
    outq.delete();
    add_pkt(0, 40, 8'h80);
    n = 0;
    while (outq.size() < 20 && n < 100) begin
      step();
      n++;
    end
    chk("F_reached_byte20", 32'(outq.size()), 32'd20);
    rst = 1'b1;
    step();
    chk("F_quiet_in_reset", 32'({last_s0r, last_s1r, last_wren}), 32'd0);
    q0.delete();
    rst = 1'b0;
    step();
    chk("F_grant_after_reset", 32'(last_grant), 32'd0);
    chk("F_busy_after_reset", 32'(last_busy), 32'd0);
    chk("F_counters_after_reset", 32'({drop_count, trunc_count}), 32'd0);
    outq.delete();
    add_pkt(0, 5, 8'h33);
    run_drain(50, "F");
    step();
    chk("F_len", 32'(outq.size()), 32'd5);
    bad = 0;
    foreach (outq[i]) begin
      if (outq[i].d !== 8'h33 + 8'(i) || outq[i].sop !== (i == 0) || outq[i].eop !== (i == 4))
        bad++;
    end
    chk("F_bytes", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
